// File: rtl/pit_event_scheduler_if.sv
// Event scheduler port bundle: PIT tick, channel config write port and
// serialised interrupt handshake with per-channel status flags.
interface pit_event_scheduler_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ID_W   = $clog2(NUM_CH)
);
    logic              tick;
    logic              cfg_we;
    logic [ID_W-1:0]   cfg_ch;
    logic              cfg_en;
    logic [CNT_W-1:0]  cfg_period;
    logic              irq;
    logic [ID_W-1:0]   irq_id;
    logic              irq_ack;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overrun;

    modport master (
        output tick, cfg_we, cfg_ch, cfg_en, cfg_period, irq_ack,
        input  irq, irq_id, pending, overrun
    );

    modport slave (
        input  tick, cfg_we, cfg_ch, cfg_en, cfg_period, irq_ack,
        output irq, irq_id, pending, overrun
    );
endinterface

// File: rtl/pit_event_scheduler.sv
// Splits the PIT tick into NUM_CH periodic event channels and serialises
// their expiries onto one interrupt line through a round-robin arbiter.
module pit_event_scheduler #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ID_W   = $clog2(NUM_CH)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    pit_event_scheduler_if.slave bus
);
    typedef enum logic {IDLE, SERVE} state_t;

    state_t            state;
    logic              irq_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   last;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ovr;
    logic [CNT_W-1:0]  period [NUM_CH];
    logic [CNT_W-1:0]  cnt    [NUM_CH];

    logic [NUM_CH-1:0] wr_hit_c;
    logic [NUM_CH-1:0] expire_c;
    logic [NUM_CH-1:0] clear_c;
    logic              grant_vld_c;
    logic [ID_W-1:0]   grant_id_c;
    int unsigned       scan_idx_c;

    // Per-channel write hit, expiry and acknowledge-clear; an out-of-range
    // cfg_ch matches no channel, and a write on a channel masks its expiry.
    always_comb begin
        wr_hit_c = '0;
        expire_c = '0;
        clear_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_hit_c[i] = bus.cfg_we && (32'(bus.cfg_ch) == i);
            expire_c[i] = bus.tick && !wr_hit_c[i] && en[i] &&
                          (period[i] != '0) && (cnt[i] == CNT_W'(1));
            clear_c[i]  = (state == SERVE) && bus.irq_ack && (32'(id_q) == i);
        end
    end

    // Round-robin search starting just above the last serviced channel.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        scan_idx_c  = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            scan_idx_c = (32'(last) + k) % NUM_CH;
            if (!grant_vld_c && pend[ID_W'(scan_idx_c)]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = ID_W'(scan_idx_c);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en   <= '0;
            pend <= '0;
            ovr  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_hit_c[i]) begin
                    en[i]     <= bus.cfg_en;
                    period[i] <= bus.cfg_period;
                    cnt[i]    <= bus.cfg_period;
                    ovr[i]    <= 1'b0;
                end else if (bus.tick && en[i] && (period[i] != '0)) begin
                    cnt[i] <= expire_c[i] ? period[i] : cnt[i] - CNT_W'(1);
                end
                // A fresh expiry beats a same-cycle acknowledge of that channel.
                if (expire_c[i]) begin
                    pend[i] <= 1'b1;
                    if (pend[i] && !clear_c[i]) begin
                        ovr[i] <= 1'b1;
                    end
                end else if (clear_c[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            irq_q <= 1'b0;
            id_q  <= '0;
            last  <= ID_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld_c) begin
                        state <= SERVE;
                        irq_q <= 1'b1;
                        id_q  <= grant_id_c;
                    end
                end
                SERVE: begin
                    if (bus.irq_ack) begin
                        state <= IDLE;
                        irq_q <= 1'b0;
                        last  <= id_q;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq     = irq_q;
    assign bus.irq_id  = id_q;
    assign bus.pending = pend;
    assign bus.overrun = ovr;
endmodule

// File: tb/tb_pit_event_scheduler.sv
// Bench for pit_event_scheduler: directed scenarios plus random traffic,
// every cycle compared against a behavioural channel/arbiter model.
module tb_pit_event_scheduler;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ID_W   = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    pit_event_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

    pit_event_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    int m_en   [NUM_CH];
    int m_per  [NUM_CH];
    int m_cnt  [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_ovr  [NUM_CH];
    bit m_serv;
    int m_id;
    int m_last;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_en[i] = 0; m_per[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
        end
        m_serv = 0;
        m_id   = 0;
        m_last = NUM_CH - 1;
    endtask

    // One clock of the behavioural model, given the inputs held across the edge.
    task automatic model_step(input bit t, input bit we, input int ch, input bit cen,
                              input int per, input bit ack);
        bit old_p [NUM_CH];
        int clr;
        bit fire;
        old_p = m_pend;
        clr   = (m_serv && ack) ? m_id : -1;
        if (m_serv) begin
            if (ack) begin
                m_serv = 0;
                m_last = m_id;
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (old_p[c]) begin
                    m_serv = 1;
                    m_id   = c;
                    break;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            fire = 0;
            if (we && ch == i) begin
                m_en[i] = cen; m_per[i] = per; m_cnt[i] = per; m_ovr[i] = 0;
            end else if (t && m_en[i] != 0 && m_per[i] != 0) begin
                if (m_cnt[i] == 1) begin
                    fire = 1;
                    m_cnt[i] = m_per[i];
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            if (i == clr) m_pend[i] = 0;
            if (fire) begin
                if (old_p[i] && i != clr) m_ovr[i] = 1;
                m_pend[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        int ep;
        int eo;
        ep = 0;
        eo = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_pend[i]) ep += (1 << i);
            if (m_ovr[i])  eo += (1 << i);
        end
        chk("irq", int'(bus.irq), int'(m_serv));
        chk("pending", int'(bus.pending), ep);
        chk("overrun", int'(bus.overrun), eo);
        if (m_serv) chk("irq_id", int'(bus.irq_id), m_id);
    endtask

    task automatic cyc(input bit t, input bit we, input int ch, input bit cen,
                       input int per, input bit ack);
        bus.tick       = t;
        bus.cfg_we     = we;
        bus.cfg_ch     = ID_W'(ch);
        bus.cfg_en     = cen;
        bus.cfg_period = CNT_W'(per);
        bus.irq_ack    = ack;
        @(posedge aclk);
        model_step(t, we, ch, cen, per, ack);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        bus.tick = 0; bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_en = 0;
        bus.cfg_period = '0; bus.irq_ack = 0;
        aresetn = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_irq_id", int'(bus.irq_id), 0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Period-2 channel: expiries on ticks 2 and 4, overrun when left unacked.
        cyc(0, 1, 0, 1, 2, 0);
        tick_n(2);
        chk("t1_pend_tick2", int'(bus.pending), 1);
        idle();
        chk("t1_irq", int'(bus.irq), 1);
        chk("t1_irq_id", int'(bus.irq_id), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t1_ack_irq_low", int'(bus.irq), 0);
        tick_n(2);
        chk("t1_pend_tick4", int'(bus.pending), 1);
        chk("t1_no_ovr", int'(bus.overrun), 0);
        tick_n(2);
        chk("t1_ovr", int'(bus.overrun), 1);

        // Round robin across three period-1 channels.
        do_reset();
        cyc(0, 1, 0, 1, 1, 0);
        cyc(0, 1, 1, 1, 1, 0);
        cyc(0, 1, 2, 1, 1, 0);
        tick_n(1);
        chk("t2_pend", int'(bus.pending), 7);
        for (int g = 0; g < 3; g++) begin
            idle();
            chk("t2_grant_id", int'(bus.irq_id), g);
            cyc(0, 0, 0, 0, 0, 1);
            chk("t2_gap_low", int'(bus.irq), 0);
        end
        tick_n(1);
        idle();
        chk("t2_wrap_id", int'(bus.irq_id), 0);

        // Disabled channel never expires; enabling restarts the full period.
        do_reset();
        cyc(0, 1, 1, 0, 3, 0);
        tick_n(6);
        chk("t3_disabled", int'(bus.pending), 0);
        cyc(0, 1, 1, 1, 3, 0);
        tick_n(2);
        chk("t3_before", int'(bus.pending), 0);
        tick_n(1);
        chk("t3_expire", int'(bus.pending), 2);

        // Write coinciding with tick: reload without decrement, overrun cleared.
        do_reset();
        cyc(0, 1, 0, 1, 1, 0);
        tick_n(2);
        chk("t4_ovr_set", int'(bus.overrun), 1);
        cyc(1, 1, 0, 1, 5, 0);
        chk("t4_ovr_clr", int'(bus.overrun), 0);
        chk("t4_pend_kept", int'(bus.pending), 1);
        cyc(0, 0, 0, 0, 0, 1);
        tick_n(4);
        chk("t4_no_early", int'(bus.pending), 0);
        tick_n(1);
        chk("t4_expire5", int'(bus.pending), 1);

        // Acknowledge together with a new expiry of the same channel.
        do_reset();
        cyc(0, 1, 3, 1, 1, 0);
        tick_n(1);
        idle();
        chk("t5_id3", int'(bus.irq_id), 3);
        cyc(1, 0, 0, 0, 0, 1);
        chk("t5_pend", int'(bus.pending), 8);
        chk("t5_ovr", int'(bus.overrun), 0);
        chk("t5_low", int'(bus.irq), 0);
        idle();
        chk("t5_rearm", int'(bus.irq), 1);
        chk("t5_rearm_id", int'(bus.irq_id), 3);

        // Asynchronous reset while serving.
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_irq", int'(bus.irq), 0);
        chk("t6_pend", int'(bus.pending), 0);
        chk("t6_ovr", int'(bus.overrun), 0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        tick_n(5);
        chk("t6_quiet", int'(bus.irq), 0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0,
                int'($urandom_range(0, NUM_CH - 1)),
                $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 4)),
                $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pit_event_scheduler.md
# pit_event_scheduler

Multiplexes the single periodic tick of the programmable interval timer (PIT) into NUM_CH independent software event channels, each with its own tick period. Expired channels raise pending flags; a round-robin arbiter serialises them onto one interrupt line with a channel ID and an acknowledge handshake. Sits between the PIT's `irq` output and the processor interrupt input; configured through a simple synchronous write port driven by the AXI-Lite register slave.

## Interface
- `NUM_CH`, 4, number of event channels (2..16)
- `CNT_W`, 16, width of each channel's period and countdown
- `ID_W`, $clog2(NUM_CH), width of channel index
- `aclk`  in  1  system clock, all logic rising-edge
- `aresetn`  in  1  reset, asynchronous and active-low
- `tick`  in  1  one-cycle pulse from PIT per expired period
- `cfg_we`  in  1  write strobe, one cycle
- `cfg_ch`  in  ID_W  channel being written
- `cfg_en`  in  1  channel enable written with the period
- `cfg_period`  in  CNT_W  channel period in ticks; 0 = never expires
- `irq`  out  1  interrupt request, level
- `irq_id`  out  ID_W  channel being serviced; valid while `irq`=1
- `irq_ack`  in  1  one-cycle acknowledge of current `irq_id`
- `pending`  out  NUM_CH  per-channel pending flags
- `overrun`  out  NUM_CH  sticky: channel expired while already pending

## Operation
- Per channel: `en`, `period[CNT_W]`, `cnt[CNT_W]`, `pending`, `overrun`.
- Write (`cfg_we`): `en`<=`cfg_en`, `period`<=`cfg_period`, `cnt`<=`cfg_period`, `overrun`<=0; `pending` untouched. Out-of-range `cfg_ch` (>= NUM_CH) ignored.
- Tick, per channel with `en`=1 and `period`!=0: `cnt`==1 → expire, `cnt`<=`period`; else `cnt`<=`cnt`-1. Disabled or period-0 channels hold `cnt`.
- Expire: `pending`<=1; if `pending` already 1 and not cleared this cycle → `overrun`<=1.
- Same-cycle `cfg_we` and `tick` on one channel: write wins, no decrement, no expire.
- Arbiter FSM, two states:
  - IDLE: `irq`=0. If any `pending`, choose first set bit searching upward from `last`+1 modulo NUM_CH; latch into `irq_id`; → SERVE.
  - SERVE: `irq`=1, `irq_id` stable. On `irq_ack`: clear `pending[irq_id]`, `last`<=`irq_id`, → IDLE. Otherwise stay.
- Same-cycle `irq_ack` and expire of serviced channel: `pending` stays 1 (new event), `overrun` not set.
- Disabling or rewriting the serviced channel in SERVE does not drop `irq`; only `irq_ack` leaves SERVE.
- `irq_ack` in IDLE ignored.

## Timing
- Reset values: `irq`=0, `irq_id`=0, `pending`=0, `overrun`=0, all `en`/`period`/`cnt`=0, FSM=IDLE, `last`=NUM_CH-1 (channel 0 wins first).
- Expire → `pending` visible the cycle after the `tick` edge.
- `pending` set → `irq`=1 one cycle later (IDLE decision registered).
- `irq_ack` at edge N → `irq`=0 and `pending` cleared after N; next grant earliest `irq`=1 after N+1 (minimum one low cycle between grants).
- Period P: expiries every P ticks; first expiry P ticks after write.
- Reset mid-SERVE: `irq` drops asynchronously, all state cleared.

## Test plan
- Reset then write ch0 en=1 period=2; 4 ticks → `pending[0]` after ticks 2 and 4, `irq`=1 with `irq_id`=0; ack after tick 2 → no overrun; skip ack across tick 4 → `overrun[0]`=1.
- ch0 period=1, ch1 period=1, ch2 period=1, all enabled, one tick → grants in order 0,1,2 with one `irq`-low cycle between acks; next tick round starts after `last`=2 at ch0.
- ch1 period=3, `cfg_en`=0 → 6 ticks produce no `pending`; rewrite `cfg_en`=1 → expiry after 3 more ticks.
- `cfg_we` on ch0 (period=5) in same cycle as `tick` → `cnt`=5 after, no decrement; `overrun[0]` cleared.
- Serve ch3 (period=1); assert `irq_ack` same cycle as next `tick` → `pending[3]` remains 1, `overrun[3]`=0, `irq` re-asserts with `irq_id`=3 after one low cycle.
- Assert `aresetn`=0 while `irq`=1 → `irq`, `pending`, `overrun` zero immediately; after release no `irq` until channels reconfigured.
